hit_input_merger: RTL and testbench

- Upstream feeder of the hit-processing top level: merges NLANES independent hit input lanes into the single write/writeSSID/writeHitInfo stream that the top level consumes, one hit per cycle.
- Buffers each lane in a small FIFO, arbitrates round-robin, applies back-pressure from the downstream stage, and tracks event boundaries.
- An event closes once every lane has delivered its end-of-event marker.

---
 rtl/hit_input_merger_pkg.sv | 23 ++
 rtl/hit_input_merger_if.sv | 40 ++++
 rtl/hit_lane_fifo.sv | 58 +++++
 rtl/hit_input_merger.sv | 178 +++++++++++++++++
 tb/tb_hit_input_merger.sv | 282 ++++++++++++++++++++++++++++
 5 files changed

// File: rtl/hit_input_merger_pkg.sv
// Shared constants and types for the hit input merger.
// Holds the hit-processing width constants (SSID / hit-info), the lane
// count and lane FIFO depth defaults, and the merger FSM state type.
package hit_input_merger_pkg;

   localparam int unsigned ROWINDEXBITS_HCM = 10;
   localparam int unsigned HITINFOBITS      = 8;

   localparam int unsigned HIM_NLANES    = 4;
   localparam int unsigned HIM_LANEDEPTH = 8;
   localparam int unsigned HIM_CNTW      = 12;

   typedef enum logic [0:0] {
      MERGE = 1'b0,
      CLOSE = 1'b1
   } mergeState_t;

   // Width of an index into n items, never less than one bit.
   function automatic int unsigned idxWidth(input int unsigned n);
      return (n > 1) ? $clog2(n) : 1;
   endfunction

endpackage

// File: rtl/hit_input_merger_if.sv
// Bus bundle between the hit input lanes, the merger and its consumer.
// Lane side: lane_valid/lane_eoe/lane_ssid/lane_info in, lane_ready out.
// Consumer side: downstream_ready in; write/writeSSID/writeHitInfo,
// eventDone/lastEventHits and sticky overflow out.
// slave is the merger's view, master is the feeder/consumer view.
interface hit_input_merger_if
   import hit_input_merger_pkg::*;
#(
   parameter int unsigned NLANES = HIM_NLANES,
   parameter int unsigned SSIDW  = ROWINDEXBITS_HCM,
   parameter int unsigned INFOW  = HITINFOBITS,
   parameter int unsigned CNTW   = HIM_CNTW
);

   logic [NLANES-1:0]       lane_valid;
   logic [NLANES-1:0]       lane_eoe;
   logic [NLANES*SSIDW-1:0] lane_ssid;
   logic [NLANES*INFOW-1:0] lane_info;
   logic [NLANES-1:0]       lane_ready;
   logic                    downstream_ready;
   logic                    write;
   logic [SSIDW-1:0]        writeSSID;
   logic [INFOW-1:0]        writeHitInfo;
   logic                    eventDone;
   logic [CNTW-1:0]         lastEventHits;
   logic                    overflow;

   modport slave (
      input  lane_valid, lane_eoe, lane_ssid, lane_info, downstream_ready,
      output lane_ready, write, writeSSID, writeHitInfo, eventDone,
             lastEventHits, overflow
   );

   modport master (
      output lane_valid, lane_eoe, lane_ssid, lane_info, downstream_ready,
      input  lane_ready, write, writeSSID, writeHitInfo, eventDone,
             lastEventHits, overflow
   );

endinterface

// File: rtl/hit_lane_fifo.sv
// Per-lane synchronous FIFO (DEPTH a power of two, at least 2).
// Ports: clk, reset (async active-low), push/wdata, pop/rdata (head word,
// valid while !empty), full, empty, count (words stored).
module hit_lane_fifo #(
   parameter int unsigned WIDTH = 19,
   parameter int unsigned DEPTH = 8
) (
   input  logic                       clk,
   input  logic                       reset,
   input  logic                       push,
   input  logic [WIDTH-1:0]           wdata,
   input  logic                       pop,
   output logic [WIDTH-1:0]           rdata,
   output logic                       full,
   output logic                       empty,
   output logic [$clog2(DEPTH):0]     count
);

   localparam int unsigned AW = $clog2(DEPTH);
   localparam int unsigned CW = AW + 1;

   logic [WIDTH-1:0] mem [DEPTH];
   logic [AW-1:0]    wrPtr;
   logic [AW-1:0]    rdPtr;
   logic [CW-1:0]    cnt;
   logic             doPush;
   logic             doPop;

   assign full   = (cnt == CW'(DEPTH));
   assign empty  = (cnt == '0);
   assign count  = cnt;
   assign rdata  = mem[rdPtr];
   assign doPush = push & ~full;
   assign doPop  = pop & ~empty;

   // Pointers and occupancy; pointers wrap naturally at the power-of-two depth.
   always_ff @(posedge clk or negedge reset) begin
      if (!reset) begin
         wrPtr <= '0;
         rdPtr <= '0;
         cnt   <= '0;
      end else begin
         if (doPush) wrPtr <= wrPtr + 1'b1;
         if (doPop)  rdPtr <= rdPtr + 1'b1;
         case ({doPush, doPop})
            2'b10:   cnt <= cnt + 1'b1;
            2'b01:   cnt <= cnt - 1'b1;
            default: cnt <= cnt;
         endcase
      end
   end

   // Storage array; contents are don't-care while the slot is empty.
   always_ff @(posedge clk) begin
      if (doPush) mem[wrPtr] <= wdata;
   end

endmodule

// File: rtl/hit_input_merger.sv
// Merges NLANES hit input lanes into one write/writeSSID/writeHitInfo stream.
// Each lane is buffered in a hit_lane_fifo, a round-robin arbiter pops one
// word per cycle while downstream_ready is high, and an event closes (one
// cycle eventDone with lastEventHits) once every lane has popped its
// end-of-event marker.
// Ports: clk, reset (async active-low), bus (hit_input_merger_if.slave).
module hit_input_merger
   import hit_input_merger_pkg::*;
#(
   parameter int unsigned NLANES    = HIM_NLANES,
   parameter int unsigned LANEDEPTH = HIM_LANEDEPTH,
   parameter int unsigned SSIDW     = ROWINDEXBITS_HCM,
   parameter int unsigned INFOW     = HITINFOBITS,
   parameter int unsigned CNTW      = HIM_CNTW
) (
   input  logic             clk,
   input  logic             reset,
   hit_input_merger_if.slave bus
);

   localparam int unsigned WORDW = 1 + SSIDW + INFOW;
   localparam int unsigned CW    = $clog2(LANEDEPTH) + 1;
   localparam int unsigned PTRW  = idxWidth(NLANES);

   typedef struct packed {
      logic             eoe;
      logic [SSIDW-1:0] ssid;
      logic [INFOW-1:0] info;
   } laneWord_t;

   laneWord_t         pushWord  [NLANES];
   laneWord_t         headWord  [NLANES];
   logic [CW-1:0]     laneCount [NLANES];
   logic [NLANES-1:0] laneFull;
   logic [NLANES-1:0] laneEmpty;
   logic [NLANES-1:0] laneReady;
   logic [NLANES-1:0] pushEn;
   logic [NLANES-1:0] popEn;
   logic [NLANES-1:0] eligible;

   mergeState_t       state, stateNext;
   logic [NLANES-1:0] doneMask, doneNext;
   logic [PTRW-1:0]   rrPtr, rrPtrNext;
   logic [CNTW-1:0]   hitCnt, hitCntNext;
   logic              writeQ, writeNext;
   logic [SSIDW-1:0]  ssidQ, ssidNext;
   logic [INFOW-1:0]  infoQ, infoNext;
   logic              eventDoneQ, eventDoneNext;
   logic [CNTW-1:0]   lastHitsQ, lastHitsNext;
   logic              overflowQ;

   logic              grantValid;
   logic [PTRW-1:0]   grantIdx;
   logic [PTRW-1:0]   candIdx;
   laneWord_t         headSel;

   // Lane buffers; a full lane refuses the word even if it pops this cycle.
   for (genvar g = 0; g < int'(NLANES); g++) begin : g_lane
      assign pushWord[g]  = {bus.lane_eoe[g],
                             bus.lane_ssid[g*SSIDW +: SSIDW],
                             bus.lane_info[g*INFOW +: INFOW]};
      assign laneReady[g] = (laneCount[g] != CW'(LANEDEPTH));
      assign pushEn[g]    = bus.lane_valid[g] & laneReady[g];
      assign eligible[g]  = ~laneEmpty[g] & ~doneMask[g];

      hit_lane_fifo #(
         .WIDTH (WORDW),
         .DEPTH (LANEDEPTH)
      ) u_fifo (
         .clk   (clk),
         .reset (reset),
         .push  (pushEn[g]),
         .wdata (pushWord[g]),
         .pop   (popEn[g]),
         .rdata (headWord[g]),
         .full  (laneFull[g]),
         .empty (laneEmpty[g]),
         .count (laneCount[g])
      );
   end

   // Round-robin: first eligible lane at or after rrPtr, wrapping.
   always_comb begin
      grantValid = 1'b0;
      grantIdx   = '0;
      candIdx    = rrPtr;
      for (int k = 0; k < int'(NLANES); k++) begin
         if (!grantValid && eligible[candIdx]) begin
            grantValid = 1'b1;
            grantIdx   = candIdx;
         end
         candIdx = (candIdx == PTRW'(NLANES - 1)) ? '0 : candIdx + 1'b1;
      end
   end

   assign headSel = headWord[grantIdx];

   // Event FSM next-state, pop selection and output next values.
   always_comb begin
      stateNext     = state;
      popEn         = '0;
      doneNext      = doneMask;
      rrPtrNext     = rrPtr;
      hitCntNext    = hitCnt;
      writeNext     = 1'b0;
      ssidNext      = ssidQ;
      infoNext      = infoQ;
      eventDoneNext = 1'b0;
      lastHitsNext  = lastHitsQ;

      case (state)
         MERGE: begin
            if (bus.downstream_ready && grantValid) begin
               popEn[grantIdx] = 1'b1;
               rrPtrNext = (grantIdx == PTRW'(NLANES - 1)) ? '0 : grantIdx + 1'b1;
               if (headSel.eoe) begin
                  doneNext[grantIdx] = 1'b1;
               end else begin
                  writeNext = 1'b1;
                  ssidNext  = headSel.ssid;
                  infoNext  = headSel.info;
                  if (hitCnt != '1) hitCntNext = hitCnt + 1'b1;
               end
               if (&doneNext) stateNext = CLOSE;
            end
         end
         CLOSE: begin
            // Words queued behind the markers wait out this cycle.
            eventDoneNext = 1'b1;
            lastHitsNext  = hitCnt;
            hitCntNext    = '0;
            doneNext      = '0;
            stateNext     = MERGE;
         end
         default: stateNext = MERGE;
      endcase
   end

   // State register.
   always_ff @(posedge clk or negedge reset) begin
      if (!reset) state <= MERGE;
      else        state <= stateNext;
   end

   // Arbiter, counter and output registers.
   always_ff @(posedge clk or negedge reset) begin
      if (!reset) begin
         doneMask   <= '0;
         rrPtr      <= '0;
         hitCnt     <= '0;
         writeQ     <= 1'b0;
         ssidQ      <= '0;
         infoQ      <= '0;
         eventDoneQ <= 1'b0;
         lastHitsQ  <= '0;
         overflowQ  <= 1'b0;
      end else begin
         doneMask   <= doneNext;
         rrPtr      <= rrPtrNext;
         hitCnt     <= hitCntNext;
         writeQ     <= writeNext;
         ssidQ      <= ssidNext;
         infoQ      <= infoNext;
         eventDoneQ <= eventDoneNext;
         lastHitsQ  <= lastHitsNext;
         overflowQ  <= overflowQ | (|(bus.lane_valid & laneFull));
      end
   end

   assign bus.lane_ready    = laneReady;
   assign bus.write         = writeQ;
   assign bus.writeSSID     = ssidQ;
   assign bus.writeHitInfo  = infoQ;
   assign bus.eventDone     = eventDoneQ;
   assign bus.lastEventHits = lastHitsQ;
   assign bus.overflow      = overflowQ;

endmodule

// File: tb/tb_hit_input_merger.sv
// Scoreboard bench for hit_input_merger: stimulus pushes expected writes and
// event closes into a queue; a negedge monitor pops and compares them.
module tb_hit_input_merger;
   import hit_input_merger_pkg::*;

   localparam int unsigned NL = HIM_NLANES;
   localparam int unsigned SW = ROWINDEXBITS_HCM;
   localparam int unsigned IW = HITINFOBITS;
   localparam int unsigned CW = HIM_CNTW;

   logic clk   = 1'b0;
   logic reset = 1'b0;
   always #5 clk = ~clk;

   hit_input_merger_if bus ();

   hit_input_merger dut (
      .clk   (clk),
      .reset (reset),
      .bus   (bus)
   );

   typedef struct {
      bit            isDone;
      logic [SW-1:0] ssid;
      logic [IW-1:0] info;
      logic [CW-1:0] hits;
   } exp_t;

   exp_t expQ[$];
   exp_t monE;
   int   checks = 0;
   int   errors = 0;
   int   cyc = 0;
   int   nWrites = 0;
   int   nDone = 0;
   int   firstWriteCyc = -1;
   int   lastWriteCyc = -1;
   int   pushCyc = 0;

   always @(posedge clk) cyc <= cyc + 1;

   task automatic check(input string name, input logic [31:0] act, input logic [31:0] req);
      checks++;
      if (act !== req) begin
         errors++;
         $display("FAIL %s: got 0x%0h, required 0x%0h", name, act, req);
      end
   endtask

   // Monitor: every write / eventDone must match the head of the queue.
   always @(negedge clk) begin
      if (reset) begin
         if (bus.write === 1'b1) begin
            nWrites++;
            if (firstWriteCyc < 0) firstWriteCyc = cyc;
            lastWriteCyc = cyc;
            if (expQ.size() == 0 || expQ[0].isDone) begin
               checks++;
               errors++;
               $display("FAIL unexpected_write: got ssid 0x%0h info 0x%0h, required no write",
                        bus.writeSSID, bus.writeHitInfo);
            end else begin
               monE = expQ.pop_front();
               check("write_ssid", 32'(bus.writeSSID), 32'(monE.ssid));
               check("write_info", 32'(bus.writeHitInfo), 32'(monE.info));
            end
         end
         if (bus.eventDone === 1'b1) begin
            nDone++;
            if (expQ.size() == 0 || !expQ[0].isDone) begin
               checks++;
               errors++;
               $display("FAIL unexpected_eventDone: got lastEventHits %0d, required no pulse",
                        bus.lastEventHits);
            end else begin
               monE = expQ.pop_front();
               check("lastEventHits", 32'(bus.lastEventHits), 32'(monE.hits));
            end
         end
      end
   end

   task automatic clearLanes();
      bus.lane_valid = '0;
      bus.lane_eoe   = '0;
   endtask

   task automatic driveLane(input int l, input bit eoe, input logic [SW-1:0] s,
                            input logic [IW-1:0] i);
      bus.lane_valid[l]         = 1'b1;
      bus.lane_eoe[l]           = eoe;
      bus.lane_ssid[l*SW +: SW] = s;
      bus.lane_info[l*IW +: IW] = i;
   endtask

   // Let one rising edge consume the driven lanes, then idle them.
   task automatic step();
      @(negedge clk);
      clearLanes();
   endtask

   task automatic expHit(input logic [SW-1:0] s, input logic [IW-1:0] i);
      exp_t e;
      e.isDone = 1'b0; e.ssid = s; e.info = i; e.hits = '0;
      expQ.push_back(e);
   endtask

   task automatic expDone(input logic [CW-1:0] h);
      exp_t e;
      e.isDone = 1'b1; e.ssid = '0; e.info = '0; e.hits = h;
      expQ.push_back(e);
   endtask

   task automatic applyReset();
      @(negedge clk);
      reset = 1'b0;
      clearLanes();
      bus.downstream_ready = 1'b0;
      repeat (2) @(negedge clk);
      expQ.delete();
      reset = 1'b1;
   endtask

   task automatic waitDrain(input int budget, input string name);
      int n = 0;
      while (expQ.size() != 0 && n < budget) begin
         @(negedge clk);
         n++;
      end
      repeat (3) @(negedge clk);
      checks++;
      if (expQ.size() != 0) begin
         errors++;
         $display("FAIL drain_%s: %0d expected outputs still pending, required 0", name, expQ.size());
      end
      expQ.delete();
   endtask

   initial begin
      #200000;
      $display("FAIL watchdog: simulation time limit reached");
      $fatal(1, "watchdog");
   end

   initial begin
      clearLanes();
      bus.lane_ssid        = '0;
      bus.lane_info        = '0;
      bus.downstream_ready = 1'b0;

      // Reset state
      @(negedge clk);
      check("rst_write", 32'(bus.write), 32'h0);
      check("rst_eventDone", 32'(bus.eventDone), 32'h0);
      check("rst_overflow", 32'(bus.overflow), 32'h0);
      check("rst_lastEventHits", 32'(bus.lastEventHits), 32'h0);
      check("rst_writeSSID", 32'(bus.writeSSID), 32'h0);
      check("rst_writeHitInfo", 32'(bus.writeHitInfo), 32'h0);
      check("rst_lane_ready", 32'(bus.lane_ready), 32'hF);
      reset = 1'b1;

      // Test 1: single hit on lane 2, two-edge latency
      bus.downstream_ready = 1'b1;
      nWrites = 0; firstWriteCyc = -1;
      driveLane(2, 1'b0, SW'(10'h005), IW'(8'hAB));
      expHit(SW'(10'h005), IW'(8'hAB));
      step();
      pushCyc = cyc;
      waitDrain(20, "t1");
      check("t1_latency", 32'(firstWriteCyc), 32'(pushCyc + 1));
      check("t1_writes", 32'(nWrites), 32'd1);

      // Test 2: three hits per lane, continuous ready, strict lane order
      applyReset();
      for (int k = 0; k < 3; k++) begin
         for (int l = 0; l < int'(NL); l++)
            driveLane(l, 1'b0, SW'(16 * l + k + 1), IW'(8'hC0 + 16 * l + k));
         step();
      end
      for (int k = 0; k < 3; k++)
         for (int l = 0; l < int'(NL); l++)
            expHit(SW'(16 * l + k + 1), IW'(8'hC0 + 16 * l + k));
      nWrites = 0; firstWriteCyc = -1;
      bus.downstream_ready = 1'b1;
      waitDrain(40, "t2");
      check("t2_writes", 32'(nWrites), 32'd12);
      check("t2_no_idle", 32'(lastWriteCyc - firstWriteCyc), 32'd11);

      // Test 3: event close after all four markers; hit behind EOE waits
      applyReset();
      nDone = 0;
      driveLane(0, 1'b0, SW'(10'h030), IW'(8'h30));
      driveLane(1, 1'b0, SW'(10'h031), IW'(8'h31));
      driveLane(2, 1'b1, '0, '0);
      driveLane(3, 1'b1, '0, '0);
      step();
      driveLane(0, 1'b0, SW'(10'h032), IW'(8'h32));
      driveLane(1, 1'b0, SW'(10'h033), IW'(8'h33));
      step();
      driveLane(0, 1'b1, '0, '0);
      driveLane(1, 1'b1, '0, '0);
      step();
      driveLane(0, 1'b0, SW'(10'h03F), IW'(8'h3F));
      step();
      expHit(SW'(10'h030), IW'(8'h30));
      expHit(SW'(10'h031), IW'(8'h31));
      expHit(SW'(10'h032), IW'(8'h32));
      expHit(SW'(10'h033), IW'(8'h33));
      expDone(CW'(4));
      expHit(SW'(10'h03F), IW'(8'h3F));
      bus.downstream_ready = 1'b1;
      waitDrain(40, "t3");
      check("t3_eventDone_count", 32'(nDone), 32'd1);

      // Test 4: back-pressure fills lane 1; ninth push overflows
      applyReset();
      for (int k = 0; k < 9; k++) begin
         driveLane(1, 1'b0, SW'(10'h200 + k), IW'(8'h50 + k));
         if (k < 8) expHit(SW'(10'h200 + k), IW'(8'h50 + k));
         step();
         if (k == 6) check("t4_ready_after7", 32'(bus.lane_ready[1]), 32'h1);
         if (k == 7) begin
            check("t4_ready_after8", 32'(bus.lane_ready[1]), 32'h0);
            check("t4_overflow_after8", 32'(bus.overflow), 32'h0);
         end
         if (k == 8) check("t4_overflow_after9", 32'(bus.overflow), 32'h1);
      end
      step();
      nWrites = 0;
      bus.downstream_ready = 1'b1;
      waitDrain(40, "t4");
      check("t4_writes", 32'(nWrites), 32'd8);
      check("t4_overflow_sticky", 32'(bus.overflow), 32'h1);

      // Test 5: async reset mid-event with five buffered words
      nDone = 0;
      driveLane(0, 1'b0, SW'(10'h011), IW'(8'h11));
      driveLane(1, 1'b0, SW'(10'h022), IW'(8'h22));
      expHit(SW'(10'h011), IW'(8'h11));
      expHit(SW'(10'h022), IW'(8'h22));
      step();
      waitDrain(20, "t5a");
      bus.downstream_ready = 1'b0;
      driveLane(0, 1'b0, SW'(10'h061), IW'(8'h61));
      driveLane(1, 1'b0, SW'(10'h062), IW'(8'h62));
      driveLane(2, 1'b0, SW'(10'h063), IW'(8'h63));
      driveLane(3, 1'b1, '0, '0);
      step();
      driveLane(0, 1'b0, SW'(10'h064), IW'(8'h64));
      step();
      #3;
      reset = 1'b0;
      #1;
      check("t5_rst_write", 32'(bus.write), 32'h0);
      check("t5_rst_eventDone", 32'(bus.eventDone), 32'h0);
      check("t5_rst_overflow", 32'(bus.overflow), 32'h0);
      check("t5_rst_writeSSID", 32'(bus.writeSSID), 32'h0);
      check("t5_rst_lane_ready", 32'(bus.lane_ready), 32'hF);
      expQ.delete();
      repeat (2) @(negedge clk);
      reset = 1'b1;
      bus.downstream_ready = 1'b1;
      driveLane(0, 1'b0, SW'(10'h044), IW'(8'h44));
      driveLane(1, 1'b0, SW'(10'h055), IW'(8'h55));
      driveLane(2, 1'b1, '0, '0);
      driveLane(3, 1'b1, '0, '0);
      expHit(SW'(10'h044), IW'(8'h44));
      expHit(SW'(10'h055), IW'(8'h55));
      expDone(CW'(2));
      step();
      driveLane(0, 1'b1, '0, '0);
      driveLane(1, 1'b1, '0, '0);
      step();
      waitDrain(40, "t5b");
      check("t5_eventDone_count", 32'(nDone), 32'd1);

      $display("Result: errors=%0d of %0d checks", errors, checks);
      $finish;
   end

endmodule
